// File: rtl/map_pkg.sv
// Shared definitions for the level-map tile RAM: default geometry, tile codes
// and the clear-sequencer state type.
package map_pkg;

  localparam int MAP_DATA_WIDTH = 3;
  localparam int MAP_DEPTH      = 192;
  localparam int MAP_ADDR_WIDTH = 8;

  localparam logic [MAP_DATA_WIDTH-1:0] TILE_EMPTY = 3'd0;
  localparam logic [MAP_DATA_WIDTH-1:0] TILE_ENEMY = 3'd1;
  localparam logic [MAP_DATA_WIDTH-1:0] TILE_WALL  = 3'd2;
  localparam logic [MAP_DATA_WIDTH-1:0] TILE_BASE  = 3'd3;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/map_clear_seq.sv
// Clear sequencer: walks ptr over every tile after reset or a clr_start request,
// then pulses clr_done for one cycle. State is exported for debug and write gating.
module map_clear_seq
  import map_pkg::*;
#(
  parameter int DEPTH      = MAP_DEPTH,
  parameter int ADDR_WIDTH = MAP_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_start,
  output logic                  clr_go,
  output logic [ADDR_WIDTH-1:0] ptr,
  output clr_state_e            state,
  output logic                  clr_busy,
  output logic                  clr_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  clr_state_e            state_d, state_q;
  logic [ADDR_WIDTH-1:0] ptr_d, ptr_q;
  logic                  busy_d, busy_q;
  logic                  done_d, done_q;

  assign clr_go = (state_q == CLR_IDLE) && clr_start;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      CLR_IDLE: begin
        if (clr_start) begin
          state_d = CLR_CLEAR;
          ptr_d   = '0;
        end
      end
      CLR_CLEAR: begin
        if (ptr_q == LAST_PTR) state_d = CLR_DONE;
        else                   ptr_d   = ptr_q + ADDR_WIDTH'(1);
      end
      CLR_DONE: state_d = CLR_IDLE;
      default:  state_d = CLR_IDLE;
    endcase
    busy_d = (state_d == CLR_CLEAR);
    done_d = (state_d == CLR_DONE);
  end

  // Reset lands directly in CLEAR: the array has no reset of its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLR_CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ptr      = ptr_q;
  assign state    = state_q;
  assign clr_busy = busy_q;
  assign clr_done = done_q;

endmodule

// File: rtl/map_tile_ram.sv
// Tile-state RAM: one checked write port, NUM_RD registered read ports, clear
// sequencer and live non-zero tile counter. MAP_TILE_RAM_BYPASS_EN selects write-first reads.
module map_tile_ram
  import map_pkg::*;
#(
  parameter int                    DATA_WIDTH = MAP_DATA_WIDTH,
  parameter int                    DEPTH      = MAP_DEPTH,
  parameter int                    ADDR_WIDTH = MAP_ADDR_WIDTH,
  parameter int                    NUM_RD     = 2,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VAL  = '0,
  localparam int                   CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  input  logic                         clr_start,
  output logic                         clr_busy,
  output logic                         clr_done,
  output logic                         wr_err,
  output logic [CNT_WIDTH-1:0]         live_cnt
);

  localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_X);
  endfunction

  logic [DATA_WIDTH-1:0]        mem_q [DEPTH];
  logic                         clr_go;
  logic [ADDR_WIDTH-1:0]        clr_ptr;
  clr_state_e                   clr_state;
  logic                         clearing;
  logic                         wr_ok;
  logic                         wr_err_d, wr_err_q;
  logic [DATA_WIDTH-1:0]        old_val;
  logic [CNT_WIDTH-1:0]         live_d, live_q;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_d, rd_q;

  map_clear_seq #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_start (clr_start),
    .clr_go    (clr_go),
    .ptr       (clr_ptr),
    .state     (clr_state),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done)
  );

  assign clearing = (clr_state == CLR_CLEAR);
  assign wr_ok    = we && !clearing && in_range(waddr);
  assign wr_err_d = we && !wr_ok;
  assign old_val  = in_range(waddr) ? mem_q[waddr] : '0;

  // Counter follows empty<->occupied transitions; a clear zeroes it up front.
  always_comb begin
    live_d = live_q;
    if (clr_go || clearing) begin
      live_d = '0;
    end else if (wr_ok) begin
      if ((old_val == '0) && (wdata != '0))      live_d = live_q + CNT_WIDTH'(1);
      else if ((old_val != '0) && (wdata == '0)) live_d = live_q - CNT_WIDTH'(1);
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] mem_rd;
    logic [DATA_WIDTH-1:0] rv;
    assign ra     = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign mem_rd = in_range(ra) ? mem_q[ra] : '0;
`ifdef MAP_TILE_RAM_BYPASS_EN
    assign rv = (wr_ok && (ra == waddr)) ? wdata : mem_rd;
`else
    assign rv = mem_rd;
`endif
    assign rd_d[i*DATA_WIDTH +: DATA_WIDTH] = clearing ? CLEAR_VAL : rv;
  end

  always_ff @(posedge clk) begin
    if (clearing)   mem_q[clr_ptr] <= CLEAR_VAL;
    else if (wr_ok) mem_q[waddr]   <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q   <= '0;
      wr_err_q <= 1'b0;
      rd_q     <= '0;
    end else begin
      live_q   <= live_d;
      wr_err_q <= wr_err_d;
      rd_q     <= rd_d;
    end
  end

  assign rd_data  = rd_q;
  assign wr_err   = wr_err_q;
  assign live_cnt = live_q;

endmodule

// File: tb/tb_map_tile_ram.sv
// Randomized scoreboard bench for map_tile_ram against a tile-array reference model;
// honours MAP_TILE_RAM_BYPASS_EN for same-cycle read/write collisions.
module tb_map_tile_ram;

  localparam int DW    = 3;
  localparam int DEPTH = 192;
  localparam int AW    = 8;
  localparam int NRD   = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;
  logic              wr_err;
  logic [CW-1:0]     live_cnt;

  always #5 clk = ~clk;

  map_tile_ram #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .NUM_RD     (NRD),
    .CLEAR_VAL  ('0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .wr_err    (wr_err),
    .live_cnt  (live_cnt)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
    logic [CW-1:0] live;
    logic          err;
    logic          busy;
    logic          done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc++;

  // Reference model: tile contents, clear cycles still to run, DONE flag.
  int m_mem [256];
  int m_rem  = 0;
  bit m_done = 0;

  function automatic int count_live();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_mem[i] != 0) n++;
    return n;
  endfunction

  function automatic int rd_model(input int a, input bit acc, input int wa,
                                  input int wd, input bit busy);
    if (busy) return 0;
`ifdef MAP_TILE_RAM_BYPASS_EN
    if (acc && (a == wa)) return wd;
`endif
    if (a >= DEPTH) return 0;
    return m_mem[a];
  endfunction

  task automatic step(input bit r, input bit w, input int wa, input int wd,
                      input int a0, input int a1, input bit cs);
    exp_t e;
    bit   busy_now;
    bit   idle_now;
    bit   acc;
    @(negedge clk);
    rst       = r;
    we        = w;
    waddr     = wa[AW-1:0];
    wdata     = wd[DW-1:0];
    rd_addr   = {a1[AW-1:0], a0[AW-1:0]};
    clr_start = cs;
    e.due = cyc + 1;
    if (r) begin
      m_rem  = DEPTH;
      m_done = 0;
      e.rd0  = '0;
      e.rd1  = '0;
      e.err  = 1'b0;
    end else begin
      busy_now = (m_rem > 0);
      idle_now = !busy_now && !m_done;
      acc      = w && !busy_now && (wa < DEPTH);
      e.err    = w && !acc;
      e.rd0    = DW'(rd_model(a0, acc, wa, wd, busy_now));
      e.rd1    = DW'(rd_model(a1, acc, wa, wd, busy_now));
      m_done   = 0;
      if (busy_now) begin
        m_mem[DEPTH - m_rem] = 0;
        m_rem--;
        m_done = (m_rem == 0);
      end else begin
        if (acc) m_mem[wa] = wd;
        if (idle_now && cs) m_rem = DEPTH;
      end
    end
    e.busy = (m_rem > 0);
    e.done = m_done;
    e.live = CW'((m_rem > 0) ? 0 : count_live());
    exp_q.push_back(e);
  endtask

  task automatic idle_rd(input int a0, input int a1);
    step(0, 0, 0, 0, a0, a1, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while ((exp_q.size() > 0) && (exp_q[0].due <= cyc)) begin
      e = exp_q.pop_front();
      chk("rd0",      32'(rd_data[DW-1:0]),    32'(e.rd0));
      chk("rd1",      32'(rd_data[2*DW-1:DW]), 32'(e.rd1));
      chk("live_cnt", 32'(live_cnt),           32'(e.live));
      chk("wr_err",   32'(wr_err),             32'(e.err));
      chk("clr_busy", 32'(clr_busy),           32'(e.busy));
      chk("clr_done", 32'(clr_done),           32'(e.done));
    end
  end

  initial begin
    int wa;
    int wd;
    bit r;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; rd_addr = '0; clr_start = 1'b0;
    for (int i = 0; i < 256; i++) m_mem[i] = 0;

    // Reset, then let the power-on clear run to completion.
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (DEPTH + 4) idle_rd($urandom_range(0, 255), $urandom_range(0, 255));

    // Fill tiles 5..7, empty tile 6, read it back.
    step(0, 1, 5, 3, 5, 6, 0);
    step(0, 1, 6, 3, 5, 6, 0);
    step(0, 1, 7, 3, 6, 7, 0);
    step(0, 1, 6, 0, 6, 7, 0);
    idle_rd(6, 7);
    idle_rd(5, 6);

    // Out-of-range write and read.
    step(0, 1, 200, 4, 200, 191, 0);
    idle_rd(200, 255);

    // Both channels read tile 7 while it is written.
    step(0, 1, 7, 5, 7, 7, 0);
    idle_rd(7, 7);

    // Clear request, write during clear, reset partway through.
    step(0, 0, 0, 0, 5, 7, 1);
    step(0, 1, 10, 2, 10, 7, 0);
    repeat (99) idle_rd($urandom_range(0, 255), $urandom_range(0, 255));
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (DEPTH + 4) idle_rd($urandom_range(0, DEPTH - 1), $urandom_range(0, 255));

    // Randomized traffic with occasional clears and resets.
    for (int n = 0; n < 1500; n++) begin
      r  = ($urandom_range(0, 599) == 0);
      wa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH, 255))
                                       : int'($urandom_range(0, 39));
      wd = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 7));
      step(r, !r && ($urandom_range(0, 2) != 0), wa, wd,
           ($urandom_range(0, 1) == 0) ? wa : int'($urandom_range(0, 47)),
           ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, 255)),
           ($urandom_range(0, 399) == 0));
    end
    repeat (3) idle_rd(0, 1);
    repeat (2) @(negedge clk);
    #1;

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
